nios2_debug_ocimem_ctrl: RTL and testbench

//  Debug monitor memory-access sequencer downstream of the debug slave sysclk stage.

---
 rtl/nios2_debug_ocimem_ctrl_if.sv | 33 +++
 rtl/nios2_debug_ocimem_ctrl.sv | 165 ++++++++++++++++
 tb/tb_nios2_debug_ocimem_ctrl.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/nios2_debug_ocimem_ctrl_if.sv
// Monitor memory master port: single-word reads/writes with waitrequest
// stall and a separate readdatavalid return.
interface nios2_debug_ocimem_ctrl_if #(
  parameter int ADDR_W = 8
);
  logic [ADDR_W-1:0] mon_address;
  logic              mon_read;
  logic              mon_write;
  logic [31:0]       mon_writedata;
  logic              mon_waitrequest;
  logic [31:0]       mon_readdata;
  logic              mon_readdatavalid;

  modport master (
    output mon_address,
    output mon_read,
    output mon_write,
    output mon_writedata,
    input  mon_waitrequest,
    input  mon_readdata,
    input  mon_readdatavalid
  );

  modport slave (
    input  mon_address,
    input  mon_read,
    input  mon_write,
    input  mon_writedata,
    output mon_waitrequest,
    output mon_readdata,
    output mon_readdatavalid
  );
endinterface

// File: rtl/nios2_debug_ocimem_ctrl.sv
// Debug monitor memory sequencer: turns JTAG take_* pulses into single
// word transactions and reports data/status back via MonDReg.
module nios2_debug_ocimem_ctrl #(
  parameter int ADDR_W  = 8,
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [37:0] jdo,
  input  logic        take_action_ocimem_a,
  input  logic        take_action_ocimem_b,
  input  logic        take_no_action_ocimem_a,
  input  logic        debugack,
  nios2_debug_ocimem_ctrl_if.master mon,
  output logic [31:0] MonDReg,
  output logic        monitor_ready,
  output logic        monitor_error
);

  localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

  typedef enum logic [1:0] {
    IDLE,
    RD_REQ,
    RD_WAIT,
    WR_REQ
  } state_e;

  state_e            state_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic [31:0]       mdr_q;
  logic              rd_q;
  logic              wr_q;
  logic              rdy_q;
  logic              err_q;
  logic [CW-1:0]     tmo_q;

  logic              pa;
  logic              pb;
  logic              pn;
  logic              multi;
  logic              idle;
  logic              go_rd;
  logic              go_wr;
  logic              busy_clr;
  logic              busy_err;
  logic              tmo_last;
  logic [ADDR_W-1:0] jdo_addr;
  logic [31:0]       jdo_wdata;
  logic [ADDR_W-1:0] addr_inc;
  logic              unused_jdo;

  assign pa        = take_action_ocimem_a;
  assign pb        = take_action_ocimem_b;
  assign pn        = take_no_action_ocimem_a;
  assign multi     = (pa & pb) | (pa & pn) | (pb & pn);
  assign idle      = (state_q == IDLE);
  // Priority a > b > no_action; losers are flagged via multi.
  assign go_rd     = pa ? jdo[35] : (~pb & pn);
  assign go_wr     = ~pa & pb;
  assign busy_clr  = pa & ~jdo[35] & jdo[34];
  assign busy_err  = pb | pn | (pa & jdo[35]);
  assign tmo_last  = (tmo_q == CW'(TIMEOUT - 1));
  assign jdo_addr  = jdo[ADDR_W+1:2];
  assign jdo_wdata = jdo[34:3];
  assign addr_inc  = addr_q + ADDR_W'(1);
  assign unused_jdo = ^jdo;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      mdr_q   <= '0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      rdy_q   <= 1'b1;
      err_q   <= 1'b0;
      tmo_q   <= '0;
    end else begin
      if (!idle && busy_clr) err_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (pa && jdo[34]) err_q <= 1'b0;
          if (pa && jdo[33]) addr_q <= jdo_addr;
          if (go_rd && debugack) begin
            state_q <= RD_REQ;
            rd_q    <= 1'b1;
            rdy_q   <= 1'b0;
            tmo_q   <= '0;
          end else if (go_wr && debugack) begin
            state_q <= WR_REQ;
            wr_q    <= 1'b1;
            rdy_q   <= 1'b0;
            tmo_q   <= '0;
            wdata_q <= jdo_wdata;
            mdr_q   <= jdo_wdata;
          end
          if (((go_rd || go_wr) && !debugack) || multi)
            err_q <= 1'b1;
        end
        RD_REQ: begin
          if (!mon.mon_waitrequest) begin
            state_q <= RD_WAIT;
            rd_q    <= 1'b0;
            tmo_q   <= '0;
          end else if (tmo_last) begin
            state_q <= IDLE;
            rd_q    <= 1'b0;
            rdy_q   <= 1'b1;
            err_q   <= 1'b1;
            tmo_q   <= '0;
          end else begin
            tmo_q <= tmo_q + CW'(1);
          end
        end
        RD_WAIT: begin
          if (mon.mon_readdatavalid) begin
            state_q <= IDLE;
            mdr_q   <= mon.mon_readdata;
            addr_q  <= addr_inc;
            rdy_q   <= 1'b1;
            tmo_q   <= '0;
          end else if (tmo_last) begin
            state_q <= IDLE;
            rdy_q   <= 1'b1;
            err_q   <= 1'b1;
            tmo_q   <= '0;
          end else begin
            tmo_q <= tmo_q + CW'(1);
          end
        end
        WR_REQ: begin
          if (!mon.mon_waitrequest) begin
            state_q <= IDLE;
            wr_q    <= 1'b0;
            addr_q  <= addr_inc;
            rdy_q   <= 1'b1;
            tmo_q   <= '0;
          end else if (tmo_last) begin
            state_q <= IDLE;
            wr_q    <= 1'b0;
            rdy_q   <= 1'b1;
            err_q   <= 1'b1;
            tmo_q   <= '0;
          end else begin
            tmo_q <= tmo_q + CW'(1);
          end
        end
      endcase
      // Set after the clear so a rejected command always leaves the flag up.
      if (!idle && busy_err) err_q <= 1'b1;
    end
  end

  assign mon.mon_address   = addr_q;
  assign mon.mon_read      = rd_q;
  assign mon.mon_write     = wr_q;
  assign mon.mon_writedata = wdata_q;
  assign MonDReg           = mdr_q;
  assign monitor_ready     = rdy_q;
  assign monitor_error     = err_q;

endmodule

// File: tb/tb_nios2_debug_ocimem_ctrl.sv
// Directed vector bench for the monitor memory sequencer.
module tb_nios2_debug_ocimem_ctrl;

  logic        clk;
  logic        reset_n;
  logic [37:0] jdo;
  logic        pa, pb, pn;
  logic        debugack;
  logic [31:0] MonDReg;
  logic        monitor_ready;
  logic        monitor_error;

  int checks;
  int errors;

  nios2_debug_ocimem_ctrl_if #(.ADDR_W(8)) mon_if ();

  nios2_debug_ocimem_ctrl #(
    .ADDR_W (8),
    .TIMEOUT(8)
  ) dut (
    .clk                    (clk),
    .reset_n                (reset_n),
    .jdo                    (jdo),
    .take_action_ocimem_a   (pa),
    .take_action_ocimem_b   (pb),
    .take_no_action_ocimem_a(pn),
    .debugack               (debugack),
    .mon                    (mon_if),
    .MonDReg                (MonDReg),
    .monitor_ready          (monitor_ready),
    .monitor_error          (monitor_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        a, b, n;
    logic [37:0] jdo;
    logic        dack, wreq, rvld;
    logic [31:0] rdata;
    logic        e_rd, e_wr;
    logic [7:0]  e_addr;
    logic        e_rdy, e_err;
    logic [31:0] e_mdr;
  } vec_t;

  vec_t tv [18];

  function automatic logic [37:0] ja(logic rd, logic clr, logic ld,
                                     logic [7:0] ad);
    logic [37:0] j;
    j = '0;
    j[35] = rd;
    j[34] = clr;
    j[33] = ld;
    j[9:2] = ad;
    return j;
  endfunction

  function automatic logic [37:0] jb(logic [31:0] d);
    logic [37:0] j;
    j = '0;
    j[34:3] = d;
    return j;
  endfunction

  function automatic vec_t mkv(
    logic a, logic b, logic n, logic [37:0] j,
    logic dack, logic wreq, logic rvld, logic [31:0] rdata,
    logic rd, logic wr, logic [7:0] ad, logic rdy, logic err,
    logic [31:0] mdr);
    vec_t v;
    v.a = a; v.b = b; v.n = n; v.jdo = j;
    v.dack = dack; v.wreq = wreq; v.rvld = rvld; v.rdata = rdata;
    v.e_rd = rd; v.e_wr = wr; v.e_addr = ad;
    v.e_rdy = rdy; v.e_err = err; v.e_mdr = mdr;
    return v;
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", nm, act, exp);
    end
  endtask

  task automatic chk_all(string p, logic rd, logic wr, logic [7:0] ad,
                         logic rdy, logic err, logic [31:0] mdr);
    chk({p, "_rd"},   {31'd0, mon_if.mon_read}, {31'd0, rd});
    chk({p, "_wr"},   {31'd0, mon_if.mon_write}, {31'd0, wr});
    chk({p, "_addr"}, {24'd0, mon_if.mon_address}, {24'd0, ad});
    chk({p, "_rdy"},  {31'd0, monitor_ready}, {31'd0, rdy});
    chk({p, "_err"},  {31'd0, monitor_error}, {31'd0, err});
    chk({p, "_mdr"},  MonDReg, mdr);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    pa = 1'b0;
    pb = 1'b0;
    pn = 1'b0;
    jdo = '0;
    mon_if.mon_readdatavalid = 1'b0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset_n = 1'b0;
    jdo = '0;
    pa = 1'b0;
    pb = 1'b0;
    pn = 1'b0;
    debugack = 1'b1;
    mon_if.mon_waitrequest = 1'b0;
    mon_if.mon_readdata = '0;
    mon_if.mon_readdatavalid = 1'b0;

    tv[0]  = mkv(1,0,0,ja(0,0,1,8'h10),1,0,0,0, 0,0,8'h10,1,0,32'h0);
    tv[1]  = mkv(0,1,0,jb(32'hDEADBEEF),1,1,0,0, 0,1,8'h10,0,0,32'hDEADBEEF);
    tv[2]  = mkv(0,0,0,'0,1,1,0,0, 0,1,8'h10,0,0,32'hDEADBEEF);
    tv[3]  = mkv(0,0,0,'0,1,1,0,0, 0,1,8'h10,0,0,32'hDEADBEEF);
    tv[4]  = mkv(0,0,0,'0,1,0,0,0, 0,0,8'h11,1,0,32'hDEADBEEF);
    tv[5]  = mkv(1,0,0,ja(1,0,1,8'hFF),1,0,0,0, 1,0,8'hFF,0,0,32'hDEADBEEF);
    tv[6]  = mkv(0,0,0,'0,1,0,0,0, 0,0,8'hFF,0,0,32'hDEADBEEF);
    tv[7]  = mkv(0,0,0,'0,1,0,0,0, 0,0,8'hFF,0,0,32'hDEADBEEF);
    tv[8]  = mkv(0,0,0,'0,1,0,0,0, 0,0,8'hFF,0,0,32'hDEADBEEF);
    tv[9]  = mkv(0,0,0,'0,1,0,1,32'h12345678, 0,0,8'h00,1,0,32'h12345678);
    tv[10] = mkv(0,0,1,'0,0,0,0,0, 0,0,8'h00,1,1,32'h12345678);
    tv[11] = mkv(1,0,0,ja(0,1,0,8'h00),0,0,0,0, 0,0,8'h00,1,0,32'h12345678);
    tv[12] = mkv(1,1,0,ja(0,0,1,8'h20),1,0,0,0, 0,0,8'h20,1,1,32'h12345678);
    tv[13] = mkv(1,0,0,ja(0,1,0,8'h00),1,0,0,0, 0,0,8'h20,1,0,32'h12345678);
    tv[14] = mkv(0,1,1,jb(32'hCAFEF00D),1,0,0,0, 0,1,8'h20,0,1,32'hCAFEF00D);
    tv[15] = mkv(0,0,0,'0,1,0,0,0, 0,0,8'h21,1,1,32'hCAFEF00D);
    tv[16] = mkv(1,0,0,ja(0,1,0,8'h00),1,0,0,0, 0,0,8'h21,1,0,32'hCAFEF00D);
    tv[17] = mkv(0,0,0,'0,1,0,1,32'hFFFFFFFF, 0,0,8'h21,1,0,32'hCAFEF00D);

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk_all("reset", 0, 0, 8'h00, 1, 0, 32'h0);
    reset_n = 1'b1;
    step();
    chk_all("post_reset", 0, 0, 8'h00, 1, 0, 32'h0);

    // Table-driven vectors: inputs applied before an edge, outputs after it
    for (int i = 0; i < 18; i++) begin
      pa = tv[i].a;
      pb = tv[i].b;
      pn = tv[i].n;
      jdo = tv[i].jdo;
      debugack = tv[i].dack;
      mon_if.mon_waitrequest = tv[i].wreq;
      mon_if.mon_readdatavalid = tv[i].rvld;
      mon_if.mon_readdata = tv[i].rdata;
      step();
      chk_all($sformatf("v%0d", i), tv[i].e_rd, tv[i].e_wr, tv[i].e_addr,
              tv[i].e_rdy, tv[i].e_err, tv[i].e_mdr);
    end

    // Read timeout: readdatavalid never comes
    debugack = 1'b1;
    mon_if.mon_waitrequest = 1'b0;
    pn = 1'b1;
    step();
    chk_all("to_req", 1, 0, 8'h21, 0, 0, 32'hCAFEF00D);
    step();
    for (int i = 1; i <= 8; i++) begin
      step();
      chk_all($sformatf("to_c%0d", i), 0, 0, 8'h21,
              (i == 8), (i == 8), 32'hCAFEF00D);
    end

    // Write attempt while a read is outstanding
    pa = 1'b1;
    jdo = ja(0, 1, 0, 8'h00);
    step();
    chk("rw_clr_err", {31'd0, monitor_error}, 32'd0);
    pn = 1'b1;
    step();
    chk_all("rw_req", 1, 0, 8'h21, 0, 0, 32'hCAFEF00D);
    step();
    chk_all("rw_wait", 0, 0, 8'h21, 0, 0, 32'hCAFEF00D);
    pb = 1'b1;
    jdo = jb(32'h11111111);
    step();
    chk_all("rw_drop_b", 0, 0, 8'h21, 0, 1, 32'hCAFEF00D);
    pa = 1'b1;
    jdo = ja(0, 1, 1, 8'h55);
    step();
    chk_all("rw_busy_clr", 0, 0, 8'h21, 0, 0, 32'hCAFEF00D);
    mon_if.mon_readdatavalid = 1'b1;
    mon_if.mon_readdata = 32'hA5A55A5A;
    step();
    chk_all("rw_done", 0, 0, 8'h22, 1, 0, 32'hA5A55A5A);

    // Asynchronous reset in the middle of a read
    mon_if.mon_waitrequest = 1'b1;
    pn = 1'b1;
    step();
    chk("ar_rd_before", {31'd0, mon_if.mon_read}, 32'd1);
    #3;
    reset_n = 1'b0;
    #1;
    chk_all("ar_reset", 0, 0, 8'h00, 1, 0, 32'h0);
    @(posedge clk);
    #2;
    reset_n = 1'b1;
    mon_if.mon_waitrequest = 1'b0;
    step();
    chk_all("ar_idle", 0, 0, 8'h00, 1, 0, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=running exp=finished");
    $fatal(1);
  end

endmodule
